// File: rtl/ccu_cmd_ctrl_if.sv
// Request/response byte-beat bus between CCU unpack/pack and the command
// controller, plus the config register port.
interface ccu_cmd_ctrl_if;
  localparam int unsigned ID_W   = 16;
  localparam int unsigned LEN_W  = 13;
  localparam int unsigned BYTE_W = 8;

  logic              unpack_busy;
  logic              unpack_en;
  logic [ID_W-1:0]   unpack_pack_id;
  logic [LEN_W-1:0]  unpack_pack_length;
  logic [BYTE_W-1:0] unpack_pack_data;
  logic [BYTE_W-1:0] unpack_pack_type;

  logic              pack_busy;
  logic              pack_dv;
  logic [ID_W-1:0]   pack_pack_id;
  logic [LEN_W-1:0]  pack_pack_length;
  logic [BYTE_W-1:0] pack_pack_data;
  logic [BYTE_W-1:0] pack_pack_type;

  logic              cfg_wr_en;
  logic [BYTE_W-1:0] cfg_addr;
  logic [BYTE_W-1:0] cfg_wdata;
  logic [BYTE_W-1:0] cfg_rdata;

  modport slave (
    input  unpack_en, unpack_pack_id, unpack_pack_length, unpack_pack_data,
           unpack_pack_type, pack_busy, cfg_rdata,
    output unpack_busy, pack_dv, pack_pack_id, pack_pack_length, pack_pack_data,
           pack_pack_type, cfg_wr_en, cfg_addr, cfg_wdata
  );

  modport master (
    output unpack_en, unpack_pack_id, unpack_pack_length, unpack_pack_data,
           unpack_pack_type, pack_busy, cfg_rdata,
    input  unpack_busy, pack_dv, pack_pack_id, pack_pack_length, pack_pack_data,
           pack_pack_type, cfg_wr_en, cfg_addr, cfg_wdata
  );
endinterface

// File: rtl/ccu_cmd_ctrl.sv
// Command controller: collects one request packet, executes PING/WRITE/READ
// against the config port, and streams back a single response packet.
module ccu_cmd_ctrl #(
  parameter int unsigned BUF_DEPTH = 16,
  parameter logic [7:0]  NAK_TYPE  = 8'hFF
) (
  input  logic           clk,
  input  logic           rst,
  ccu_cmd_ctrl_if.slave  ccu_io
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned LEN_W = 13;

  localparam logic [7:0] TYPE_PING  = 8'h01;
  localparam logic [7:0] TYPE_WRITE = 8'h02;
  localparam logic [7:0] TYPE_READ  = 8'h03;
  localparam logic [7:0] RSP_PING   = 8'h81;
  localparam logic [7:0] RSP_WRITE  = 8'h82;
  localparam logic [7:0] RSP_READ   = 8'h83;

  typedef enum logic [2:0] {S_IDLE, S_RX, S_EXEC, S_RD_WAIT, S_TX} state_e;
  typedef enum logic [1:0] {CMD_PING, CMD_WRITE, CMD_READ, CMD_NAK} cmd_e;

  state_e            state_q;
  cmd_e              cmd_q;
  logic [15:0]       id_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        type_q;
  logic [LEN_W-1:0]  rx_cnt_q;
  logic [LEN_W-1:0]  tx_cnt_q;
  logic [7:0]        buf_q [BUF_DEPTH];

  logic              unpack_busy_q;
  logic              pack_dv_q;
  logic [15:0]       pack_id_q;
  logic [LEN_W-1:0]  pack_len_q;
  logic [7:0]        pack_data_q;
  logic [7:0]        pack_type_q;
  logic              cfg_wr_en_q;
  logic [7:0]        cfg_addr_q;
  logic [7:0]        cfg_wdata_q;

  logic              rx_acc_c;
  logic              tx_acc_c;
  logic              first_c;
  logic              last_c;
  logic              tx_last_c;
  logic [LEN_W-1:0]  eff_len_c;
  logic [7:0]        eff_type_c;
  logic [7:0]        byte0_c;
  logic [LEN_W-1:0]  wr_idx_c;
  cmd_e              dec_cmd_c;

  assign first_c    = (state_q == S_IDLE);
  assign rx_acc_c   = ccu_io.unpack_en && !unpack_busy_q &&
                      ((state_q == S_IDLE) || (state_q == S_RX));
  assign tx_acc_c   = (state_q == S_TX) && pack_dv_q && !ccu_io.pack_busy;
  assign eff_len_c  = first_c ? ccu_io.unpack_pack_length : len_q;
  assign eff_type_c = first_c ? ccu_io.unpack_pack_type   : type_q;
  assign byte0_c    = first_c ? ccu_io.unpack_pack_data   : buf_q[0];
  assign wr_idx_c   = first_c ? '0 : rx_cnt_q;
  assign last_c     = first_c ? (ccu_io.unpack_pack_length <= LEN_W'(1))
                              : ((rx_cnt_q + LEN_W'(1)) == len_q);
  assign tx_last_c  = (pack_len_q <= LEN_W'(1)) || ((tx_cnt_q + LEN_W'(1)) == pack_len_q);

  // Decode is evaluated on the last request beat so cfg strobes are registered into EXEC.
  always_comb begin
    dec_cmd_c = CMD_NAK;
    case (eff_type_c)
      TYPE_PING:  if (eff_len_c <= LEN_W'(BUF_DEPTH)) dec_cmd_c = CMD_PING;
      TYPE_WRITE: if (eff_len_c == LEN_W'(2))         dec_cmd_c = CMD_WRITE;
      TYPE_READ:  if (eff_len_c == LEN_W'(1))         dec_cmd_c = CMD_READ;
      default:    dec_cmd_c = CMD_NAK;
    endcase
  end

  // Payload buffer; bytes beyond BUF_DEPTH are dropped.
  always_ff @(posedge clk) begin
    if (rx_acc_c && (wr_idx_c < LEN_W'(BUF_DEPTH))) begin
      buf_q[PTR_W'(wr_idx_c)] <= ccu_io.unpack_pack_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= CMD_NAK;
      id_q          <= '0;
      len_q         <= '0;
      type_q        <= '0;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      unpack_busy_q <= 1'b0;
      pack_dv_q     <= 1'b0;
      pack_id_q     <= '0;
      pack_len_q    <= '0;
      pack_data_q   <= '0;
      pack_type_q   <= '0;
      cfg_wr_en_q   <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_wdata_q   <= '0;
    end else begin
      cfg_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RX: begin
          if (rx_acc_c) begin
            if (first_c) begin
              id_q   <= ccu_io.unpack_pack_id;
              len_q  <= ccu_io.unpack_pack_length;
              type_q <= ccu_io.unpack_pack_type;
            end
            if (last_c) begin
              state_q       <= S_EXEC;
              rx_cnt_q      <= '0;
              unpack_busy_q <= 1'b1;
              cmd_q         <= dec_cmd_c;
              if ((dec_cmd_c == CMD_WRITE) || (dec_cmd_c == CMD_READ)) begin
                cfg_addr_q <= byte0_c;
              end
              if (dec_cmd_c == CMD_WRITE) begin
                cfg_wr_en_q <= 1'b1;
                cfg_wdata_q <= ccu_io.unpack_pack_data;
              end
            end else begin
              state_q  <= S_RX;
              rx_cnt_q <= wr_idx_c + LEN_W'(1);
            end
          end
        end
        S_EXEC: begin
          pack_id_q <= id_q;
          tx_cnt_q  <= '0;
          state_q   <= S_TX;
          pack_dv_q <= 1'b1;
          case (cmd_q)
            CMD_PING: begin
              pack_type_q <= RSP_PING;
              pack_len_q  <= len_q;
              pack_data_q <= (len_q == '0) ? 8'h00 : buf_q[0];
            end
            CMD_WRITE: begin
              pack_type_q <= RSP_WRITE;
              pack_len_q  <= LEN_W'(1);
              pack_data_q <= 8'h00;
            end
            CMD_READ: begin
              state_q   <= S_RD_WAIT;
              pack_dv_q <= 1'b0;
            end
            default: begin
              pack_type_q <= NAK_TYPE;
              pack_len_q  <= LEN_W'(1);
              pack_data_q <= type_q;
            end
          endcase
        end
        S_RD_WAIT: begin
          pack_type_q <= RSP_READ;
          pack_len_q  <= LEN_W'(1);
          pack_data_q <= ccu_io.cfg_rdata;
          pack_dv_q   <= 1'b1;
          state_q     <= S_TX;
        end
        S_TX: begin
          if (tx_acc_c) begin
            if (tx_last_c) begin
              state_q       <= S_IDLE;
              pack_dv_q     <= 1'b0;
              unpack_busy_q <= 1'b0;
              tx_cnt_q      <= '0;
            end else begin
              tx_cnt_q    <= tx_cnt_q + LEN_W'(1);
              pack_data_q <= buf_q[PTR_W'(tx_cnt_q + LEN_W'(1))];
            end
          end
        end
        default: begin
          state_q       <= S_IDLE;
          pack_dv_q     <= 1'b0;
          unpack_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign ccu_io.unpack_busy      = unpack_busy_q;
  assign ccu_io.pack_dv          = pack_dv_q;
  assign ccu_io.pack_pack_id     = pack_id_q;
  assign ccu_io.pack_pack_length = pack_len_q;
  assign ccu_io.pack_pack_data   = pack_data_q;
  assign ccu_io.pack_pack_type   = pack_type_q;
  assign ccu_io.cfg_wr_en        = cfg_wr_en_q;
  assign ccu_io.cfg_addr         = cfg_addr_q;
  assign ccu_io.cfg_wdata        = cfg_wdata_q;

endmodule
